// File: rtl/int_log_seq.sv
// Sequential integer logarithm: finds ceil/floor(log_B T) by repeated multiplication,
// one multiply per clock, behind a start/done handshake.
module int_log_seq #(
  parameter int W  = 16,
  parameter int RW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [W-1:0]  target,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [W-1:0]   base_q;
  logic [W-1:0]   target_q;
  logic           mode_q;
  logic [W:0]     pow;
  logic [RW-1:0]  k;
  logic [2*W-1:0] product;
  logic [W:0]     pow_next;
  logic           reached;

  // A multiply only happens while pow < T < 2^W, so pow[W] is always 0 here.
  always_comb begin
    product  = {{W{1'b0}}, pow[W-1:0]} * {{W{1'b0}}, base_q};
    pow_next = {1'b0, product[W-1:0]};
    if (|product[2*W-1:W]) pow_next = {1'b1, {W{1'b0}}};
    reached  = (pow >= {1'b0, target_q});
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      target_q <= '0;
      mode_q   <= 1'b0;
      pow      <= '0;
      k        <= '0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base;
            target_q <= target;
            mode_q   <= mode;
            result   <= '0;
            pow      <= {{W{1'b0}}, 1'b1};
            k        <= '0;
            if (base < W'(2) || target == '0) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (reached) begin
            // Floor steps back one unless the power landed exactly on T.
            if (!mode_q || pow == {1'b0, target_q}) result <= k;
            else                                     result <= k - RW'(1);
            state <= DONE;
          end else begin
            pow <= pow_next;
            k   <= k + RW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_log_seq.sv
// Self-checking bench for int_log_seq: directed vector table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_int_log_seq;

  localparam int W  = 16;
  localparam int RW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  base;
  logic [W-1:0]  target;
  logic          mode;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  int_log_seq #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .target(target),
    .mode(mode), .busy(busy), .done(done), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: unbounded arithmetic, no saturation needed at 64 bits.
  task automatic model(input int b, input int t, input bit m,
                       output int res, output bit e, output int lat);
    longint p;
    int kk;
    if (b < 2 || t == 0) begin
      res = 0; e = 1'b1; lat = 0;
    end else begin
      p = 1; kk = 0;
      while (p < t) begin
        p = p * b;
        kk++;
      end
      e   = 1'b0;
      lat = kk + 1;
      res = (m == 1'b0 || p == t) ? kk : kk - 1;
    end
  endtask

  // Present start at a falling edge, count rising edges after the accepting
  // edge until done is seen (0 means done right after the accepting edge).
  task automatic launch(input int b, input int t, input bit m);
    @(negedge clk);
    base = W'(b); target = W'(t); mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output bit timed_out);
    edges = 0;
    timed_out = 1'b0;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) timed_out = 1'b1;
  endtask

  task automatic run_op(input string tag, input int b, input int t, input bit m,
                        input int exp_res, input bit exp_err, input int exp_lat);
    int edges;
    bit to;
    launch(b, t, m);
    wait_done(edges, to);
    check({tag, " done_timeout"}, to, 0);
    if (!to) begin
      check({tag, " latency"}, edges, exp_lat);
      check({tag, " result"}, result, exp_res);
      check({tag, " err"}, err, exp_err);
      @(posedge clk);
      #1;
      check({tag, " done_pulse_len"}, {busy, done}, 0);
      check({tag, " result_held"}, result, exp_res);
    end
  endtask

  typedef struct {
    int b;
    int t;
    bit m;
    int res;
    bit e;
    int lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int edges;
    bit to;
    int r_res, r_lat;
    bit r_e;

    vecs = '{
      '{3,     10,    1'b0, 3,  1'b0, 4},
      '{3,     9,     1'b1, 2,  1'b0, 3},
      '{3,     10,    1'b1, 2,  1'b0, 4},
      '{3,     9,     1'b0, 2,  1'b0, 3},
      '{2,     65535, 1'b0, 16, 1'b0, 17},
      '{2,     65535, 1'b1, 15, 1'b0, 17},
      '{300,   65000, 1'b0, 2,  1'b0, 3},
      '{300,   65000, 1'b1, 1,  1'b0, 3},
      '{65535, 65535, 1'b0, 1,  1'b0, 2},
      '{65535, 65535, 1'b1, 1,  1'b0, 2},
      '{1,     5,     1'b0, 0,  1'b1, 0},
      '{0,     5,     1'b1, 0,  1'b1, 0},
      '{5,     0,     1'b0, 0,  1'b1, 0},
      '{7,     1,     1'b0, 0,  1'b0, 1},
      '{7,     1,     1'b1, 0,  1'b0, 1}
    };

    rst_n = 1'b0; start = 1'b0; base = '0; target = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].t, vecs[i].m,
             vecs[i].res, vecs[i].e, vecs[i].lat);

    // Start while running is ignored; first operands still produce the answer.
    launch(2, 40000, 1'b0);
    check("seq_ignore busy", busy, 1);
    repeat (3) @(negedge clk);
    base = 3; target = 5; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, to);
    check("seq_ignore timeout", to, 0);
    check("seq_ignore result", result, 16);
    check("seq_ignore err", err, 0);
    @(posedge clk);
    #1;
    check("seq_ignore no_requeue", busy, 0);

    // Reset mid-run aborts immediately without a done pulse.
    launch(2, 40000, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 2, 40000, 1'b1, 15, 1'b0, 17);

    for (int i = 0; i < 40; i++) begin
      int b, t;
      bit m;
      b = (i % 4 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20));
      t = (i % 5 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
      m = 1'($urandom_range(0, 1));
      model(b, t, m, r_res, r_e, r_lat);
      run_op($sformatf("rand%0d b=%0d t=%0d m=%0d", i, b, t, m), b, t, m, r_res, r_e, r_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
